m_memarb: RTL and testbench

M_MEMARB -- requirements
Module: m_memarb

---
 rtl/m_memarb_pkg.sv | 29 ++
 rtl/m_memarb_if.sv | 45 ++++
 rtl/m_memarb_arbcnt.sv | 23 ++
 rtl/m_memarb.sv | 106 ++++++++++
 tb/tb_m_memarb.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/m_memarb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the grant-state encoding and the default widths used by every file.
package m_memarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IRD  = 2'd1,
    ST_DRD  = 2'd2,
    ST_DWR  = 2'd3
  } state_t;

  localparam int AW_DEF = 12;
  localparam int CNT_W  = 16;

  // Encodes this cycle's grant as the state the arbiter holds next cycle.
  function automatic state_t grant_state(input logic igrant, input logic dgrant,
                                         input logic dwe);
    state_t st;
    if (igrant) begin
      st = ST_IRD;
    end else if (dgrant) begin
      st = dwe ? ST_DWR : ST_DRD;
    end else begin
      st = ST_IDLE;
    end
    return st;
  endfunction

endpackage

// File: rtl/m_memarb_if.sv
// Bundle of requester, memory-side and statistics signals of the arbiter.
// slave is the arbiter view; master is the view of the surrounding system.
interface m_memarb_if
  import m_memarb_pkg::*;
#(
  parameter int AW = AW_DEF
);

  logic             w_ireq;
  logic [AW-1:0]    w_iaddr;
  logic             w_dreq;
  logic             w_dwe;
  logic [AW-1:0]    w_daddr;
  logic [31:0]      w_ddin;

  logic             w_igrant;
  logic             w_dgrant;
  logic             w_istall;
  logic             w_dstall;
  logic             r_ivalid;
  logic             r_dvalid;
  logic [31:0]      w_rdata;

  logic [AW-1:0]    w_maddr;
  logic             w_mwe;
  logic [31:0]      w_mdin;
  logic [31:0]      w_mdout;

  logic [CNT_W-1:0] r_icnt;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_ccnt;

  modport slave (
    input  w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_ddin, w_mdout,
    output w_igrant, w_dgrant, w_istall, w_dstall, r_ivalid, r_dvalid,
    output w_rdata, w_maddr, w_mwe, w_mdin, r_icnt, r_dcnt, r_ccnt
  );

  modport master (
    output w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_ddin, w_mdout,
    input  w_igrant, w_dgrant, w_istall, w_dstall, r_ivalid, r_dvalid,
    input  w_rdata, w_maddr, w_mwe, w_mdin, r_icnt, r_dcnt, r_ccnt
  );

endinterface

// File: rtl/m_memarb_arbcnt.sv
// Wrapping event counter used for the grant and conflict statistics.
// Cleared asynchronously by reset, advances by one on each enabled edge.
module m_arbcnt
  import m_memarb_pkg::*;
(
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_en,
  output logic [CNT_W-1:0] r_cnt
);

  // Counter register; natural overflow gives the FFFF -> 0 wrap.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_en) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/m_memarb.sv
// Two-port arbiter sharing one registered 1-cycle-latency memory between an
// instruction fetch port and a data port, data first with starvation relief.
module m_memarb
  import m_memarb_pkg::*;
#(
  parameter int STARVE_LIM = 3,
  parameter int AW         = AW_DEF
) (
  input logic        w_clk,
  input logic        w_rst_n,
  m_memarb_if.slave  bus
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     r_state;
  state_t     state_next_s;
  logic [3:0] r_starve;
  logic [3:0] starve_next_s;
  logic       both_s;
  logic       igrant_s;
  logic       dgrant_s;
  logic       ivalid_r;
  logic       dvalid_r;

  // Grant decision; reset forces both grants low so nothing reaches memory.
  always_comb begin
    both_s   = 1'b0;
    igrant_s = 1'b0;
    dgrant_s = 1'b0;
    if (w_rst_n) begin
      both_s = bus.w_ireq & bus.w_dreq;
      if (both_s) begin
        if (r_starve == LIM) begin
          igrant_s = 1'b1;
        end else begin
          dgrant_s = 1'b1;
        end
      end else begin
        igrant_s = bus.w_ireq;
        dgrant_s = bus.w_dreq;
      end
    end else begin
      both_s   = 1'b0;
    end
  end

  // Starvation count only grows on cycles where the instruction port lost.
  always_comb begin
    starve_next_s = 4'd0;
    if (both_s && !igrant_s) begin
      starve_next_s = r_starve + 4'd1;
    end else begin
      starve_next_s = 4'd0;
    end
  end

  // Next state follows the current grant every cycle.
  always_comb begin
    state_next_s = ST_IDLE;
    state_next_s = grant_state(igrant_s, dgrant_s, bus.w_dwe);
  end

  // State, starvation count and read-valid flags.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_IDLE;
      r_starve <= 4'd0;
      ivalid_r <= 1'b0;
      dvalid_r <= 1'b0;
    end else begin
      r_state  <= state_next_s;
      r_starve <= starve_next_s;
      ivalid_r <= (state_next_s == ST_IRD);
      dvalid_r <= (state_next_s == ST_DRD);
    end
  end

  // Memory-side mux: address of the winner, zero when idle.
  always_comb begin
    bus.w_maddr = {AW{1'b0}};
    bus.w_mwe   = 1'b0;
    if (igrant_s) begin
      bus.w_maddr = bus.w_iaddr;
    end else if (dgrant_s) begin
      bus.w_maddr = bus.w_daddr;
      bus.w_mwe   = bus.w_dwe;
    end else begin
      bus.w_maddr = {AW{1'b0}};
    end
  end

  assign bus.w_mdin   = bus.w_ddin;
  assign bus.w_rdata  = bus.w_mdout;
  assign bus.w_igrant = igrant_s;
  assign bus.w_dgrant = dgrant_s;
  assign bus.w_istall = bus.w_ireq & ~igrant_s;
  assign bus.w_dstall = bus.w_dreq & ~dgrant_s;
  assign bus.r_ivalid = ivalid_r;
  assign bus.r_dvalid = dvalid_r;

  m_arbcnt u_icnt (.w_clk(w_clk), .w_rst_n(w_rst_n), .w_en(igrant_s), .r_cnt(bus.r_icnt));
  m_arbcnt u_dcnt (.w_clk(w_clk), .w_rst_n(w_rst_n), .w_en(dgrant_s), .r_cnt(bus.r_dcnt));
  m_arbcnt u_ccnt (.w_clk(w_clk), .w_rst_n(w_rst_n), .w_en(both_s),   .r_cnt(bus.r_ccnt));

endmodule

// File: tb/tb_m_memarb.sv
// Self-checking bench for m_memarb: a registered 4K-word memory model plus a
// queue of expected read returns, exercised one scenario task at a time.
module tb_m_memarb;
  import m_memarb_pkg::*;

  typedef struct {
    logic        port_i;
    logic [31:0] data;
  } exp_t;

  logic w_clk = 1'b0;
  logic w_rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] exp_mem [0:4095];
  logic [31:0] mem [0:4095];
  bit          mem_loaded = 1'b0;
  logic [15:0] exp_icnt = 16'd0;
  logic [15:0] exp_dcnt = 16'd0;
  logic [15:0] exp_ccnt = 16'd0;

  m_memarb_if #(.AW(12)) bus ();

  m_memarb #(.STARVE_LIM(3), .AW(12)) dut (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .bus    (bus)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [31:0] init_word(input int a);
    return (a == 5) ? 32'h0000_1234 : (32'hA5A5_0000 | 32'(a));
  endfunction

  // Registered memory with one cycle of read latency.
  always @(posedge w_clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.w_mwe) begin
      mem[bus.w_maddr] <= bus.w_mdin;
    end
    bus.w_mdout <= mem[bus.w_maddr];
  end

  task automatic drive(input logic ireq, input logic [11:0] iaddr, input logic dreq,
                       input logic dwe, input logic [11:0] daddr, input logic [31:0] ddin);
    bus.w_ireq = ireq; bus.w_iaddr = iaddr; bus.w_dreq = dreq;
    bus.w_dwe = dwe; bus.w_daddr = daddr; bus.w_ddin = ddin;
  endtask

  task automatic next_cycle();
    @(posedge w_clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 12'd5, 1'b1, 1'b1, 12'd3, 32'hDEAD_BEEF);
    w_rst_n = 1'b0;
    #3;
    checks++; if (bus.w_igrant !== 1'b0 || bus.w_dgrant !== 1'b0) begin failures++; $display("FAIL reset_grants got=%b%b exp=00", bus.w_igrant, bus.w_dgrant); end
    checks++; if (bus.w_mwe !== 1'b0) begin failures++; $display("FAIL reset_mwe got=%b exp=0", bus.w_mwe); end
    next_cycle();
    next_cycle();
    checks++; if (bus.r_ivalid !== 1'b0 || bus.r_dvalid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b%b exp=00", bus.r_ivalid, bus.r_dvalid); end
    checks++; if (bus.r_icnt !== 16'd0 || bus.r_dcnt !== 16'd0 || bus.r_ccnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h/%0h exp=0/0/0", bus.r_icnt, bus.r_dcnt, bus.r_ccnt); end
    checks++; if (dut.r_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.r_state); end
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    #2 w_rst_n = 1'b1;
  endtask

  task automatic test_iread();
    drive(1'b1, 12'd5, 1'b0, 1'b0, 12'd0, 32'd0);
    #1;
    checks++; if (bus.w_igrant !== 1'b1 || bus.w_dgrant !== 1'b0) begin failures++; $display("FAIL iread_grant got=%b%b exp=10", bus.w_igrant, bus.w_dgrant); end
    checks++; if (bus.w_istall !== 1'b0 || bus.w_maddr !== 12'd5) begin failures++; $display("FAIL iread_bus got stall=%b addr=%0d exp stall=0 addr=5", bus.w_istall, bus.w_maddr); end
    sb.push_back('{1'b1, exp_mem[5]});
    exp_icnt++;
    next_cycle();
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    e = sb.pop_front();
    checks++; if (bus.r_ivalid !== 1'b1 || bus.r_dvalid !== 1'b0) begin failures++; $display("FAIL iread_valid got=%b%b exp=10", bus.r_ivalid, bus.r_dvalid); end
    checks++; if (bus.w_rdata !== e.data) begin failures++; $display("FAIL iread_data got=%0h exp=%0h", bus.w_rdata, e.data); end
    checks++; if (bus.r_icnt !== 16'd1) begin failures++; $display("FAIL iread_icnt got=%0d exp=1", bus.r_icnt); end
    next_cycle();
    checks++; if (bus.r_ivalid !== 1'b0) begin failures++; $display("FAIL iread_valid_drop got=%b exp=0", bus.r_ivalid); end
  endtask

  // Runs n cycles of read requests with given per-cycle request/grant patterns.
  task automatic test_arbitrate(input string name, input int n, input logic [15:0] ireq_p,
                                input logic [15:0] dreq_p, input logic [15:0] ig_p,
                                input logic [15:0] dg_p);
    logic [11:0] ia, da;
    logic        prev_g;
    prev_g = 1'b0;
    for (int c = 0; c <= n; c++) begin
      if (prev_g) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL %s_sb_empty cycle=%0d", name, c);
        end else begin
          e = sb.pop_front();
          checks++; if (bus.r_ivalid !== e.port_i || bus.r_dvalid !== !e.port_i) begin failures++; $display("FAIL %s_valid cycle=%0d got=%b%b exp=%b%b", name, c, bus.r_ivalid, bus.r_dvalid, e.port_i, !e.port_i); end
          checks++; if (bus.w_rdata !== e.data) begin failures++; $display("FAIL %s_data cycle=%0d got=%0h exp=%0h", name, c, bus.w_rdata, e.data); end
        end
      end
      if (c == n) break;
      ia = 12'(100 + c * 3);
      da = 12'(200 + c * 7);
      drive(ireq_p[c], ia, dreq_p[c], 1'b0, da, 32'h0);
      #1;
      checks++; if (bus.w_igrant !== ig_p[c] || bus.w_dgrant !== dg_p[c]) begin failures++; $display("FAIL %s_grant cycle=%0d got=%b%b exp=%b%b", name, c, bus.w_igrant, bus.w_dgrant, ig_p[c], dg_p[c]); end
      checks++; if (bus.w_istall !== (ireq_p[c] & !ig_p[c]) || bus.w_dstall !== (dreq_p[c] & !dg_p[c])) begin failures++; $display("FAIL %s_stall cycle=%0d got=%b%b", name, c, bus.w_istall, bus.w_dstall); end
      if (ig_p[c]) sb.push_back('{1'b1, exp_mem[ia]});
      if (dg_p[c]) sb.push_back('{1'b0, exp_mem[da]});
      prev_g = ig_p[c] | dg_p[c];
      exp_icnt += {15'd0, ig_p[c]};
      exp_dcnt += {15'd0, dg_p[c]};
      exp_ccnt += {15'd0, ireq_p[c] & dreq_p[c]};
      next_cycle();
      drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    end
    checks++; if (bus.r_icnt !== exp_icnt || bus.r_dcnt !== exp_dcnt || bus.r_ccnt !== exp_ccnt) begin failures++; $display("FAIL %s_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", name, bus.r_icnt, bus.r_dcnt, bus.r_ccnt, exp_icnt, exp_dcnt, exp_ccnt); end
    next_cycle();
  endtask

  task automatic test_write_read();
    drive(1'b0, 12'd0, 1'b1, 1'b1, 12'd7, 32'h0000_CAFE);
    #1;
    checks++; if (bus.w_dgrant !== 1'b1 || bus.w_mwe !== 1'b1) begin failures++; $display("FAIL wr_grant got g=%b we=%b exp 1 1", bus.w_dgrant, bus.w_mwe); end
    checks++; if (bus.w_maddr !== 12'd7 || bus.w_mdin !== 32'h0000_CAFE) begin failures++; $display("FAIL wr_bus got addr=%0d din=%0h exp 7 cafe", bus.w_maddr, bus.w_mdin); end
    exp_mem[7] = 32'h0000_CAFE;
    exp_dcnt++;
    next_cycle();
    drive(1'b0, 12'd0, 1'b1, 1'b0, 12'd7, 32'h0);
    checks++; if (bus.r_dvalid !== 1'b0) begin failures++; $display("FAIL wr_novalid got=%b exp=0", bus.r_dvalid); end
    #1;
    checks++; if (bus.w_dgrant !== 1'b1 || bus.w_mwe !== 1'b0) begin failures++; $display("FAIL rd_after_wr got g=%b we=%b exp 1 0", bus.w_dgrant, bus.w_mwe); end
    sb.push_back('{1'b0, exp_mem[7]});
    exp_dcnt++;
    next_cycle();
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'h0);
    e = sb.pop_front();
    checks++; if (bus.r_dvalid !== 1'b1 || bus.w_rdata !== e.data) begin failures++; $display("FAIL rd_after_wr_data got v=%b d=%0h exp v=1 d=%0h", bus.r_dvalid, bus.w_rdata, e.data); end
    checks++; if (bus.r_dcnt !== exp_dcnt) begin failures++; $display("FAIL wr_dcnt got=%0d exp=%0d", bus.r_dcnt, exp_dcnt); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 12'd0, 1'b1, 1'b0, 12'd9, 32'h0);
    #1;
    sb.push_back('{1'b0, exp_mem[9]});
    next_cycle();
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'h0);
    e = sb.pop_front();
    checks++; if (bus.r_dvalid !== 1'b1 || bus.w_rdata !== e.data) begin failures++; $display("FAIL rstmid_pre got v=%b d=%0h exp v=1 d=%0h", bus.r_dvalid, bus.w_rdata, e.data); end
    #2 w_rst_n = 1'b0;
    #1;
    checks++; if (bus.r_dvalid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.r_dvalid); end
    checks++; if (bus.r_icnt !== 16'd0 || bus.r_dcnt !== 16'd0 || bus.r_ccnt !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d/%0d exp=0/0/0", bus.r_icnt, bus.r_dcnt, bus.r_ccnt); end
    exp_icnt = 16'd0; exp_dcnt = 16'd0; exp_ccnt = 16'd0;
    #2 w_rst_n = 1'b1;
    next_cycle();
    checks++; if (bus.r_dvalid !== 1'b0 || dut.r_state !== ST_IDLE) begin failures++; $display("FAIL rstmid_after got v=%b st=%0d exp v=0 st=0", bus.r_dvalid, dut.r_state); end
    // Reset during the grant cycle itself: the read never completes.
    drive(1'b0, 12'd0, 1'b1, 1'b0, 12'd11, 32'h0);
    #1;
    checks++; if (bus.w_dgrant !== 1'b1) begin failures++; $display("FAIL rstgrant_pre got=%b exp=1", bus.w_dgrant); end
    w_rst_n = 1'b0;
    #1;
    checks++; if (bus.w_dgrant !== 1'b0) begin failures++; $display("FAIL rstgrant_forced got=%b exp=0", bus.w_dgrant); end
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'h0);
    #1 w_rst_n = 1'b1;
    next_cycle();
    checks++; if (bus.r_dvalid !== 1'b0 || bus.r_dcnt !== 16'd0) begin failures++; $display("FAIL rstgrant_after got v=%b dcnt=%0d exp v=0 dcnt=0", bus.r_dvalid, bus.r_dcnt); end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 12'(c), 1'b0, 1'b1, 12'(c + 40), 32'h5555_0000);
      #1;
      checks++; if (bus.w_igrant !== 1'b0 || bus.w_dgrant !== 1'b0 || bus.w_mwe !== 1'b0 || bus.w_maddr !== 12'd0) begin failures++; $display("FAIL idle_bus cycle=%0d got g=%b%b we=%b a=%0d", c, bus.w_igrant, bus.w_dgrant, bus.w_mwe, bus.w_maddr); end
      next_cycle();
      checks++; if (dut.r_state !== ST_IDLE || bus.r_ivalid !== 1'b0 || bus.r_dvalid !== 1'b0) begin failures++; $display("FAIL idle_state cycle=%0d got st=%0d v=%b%b", c, dut.r_state, bus.r_ivalid, bus.r_dvalid); end
    end
    checks++; if (bus.r_icnt !== exp_icnt || bus.r_dcnt !== exp_dcnt || bus.r_ccnt !== exp_ccnt) begin failures++; $display("FAIL idle_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.r_icnt, bus.r_dcnt, bus.r_ccnt, exp_icnt, exp_dcnt, exp_ccnt); end
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'h0);
  endtask

  task automatic test_wrap();
    checks++; if (bus.r_dcnt !== 16'd0) begin failures++; $display("FAIL wrap_start got=%0d exp=0", bus.r_dcnt); end
    drive(1'b0, 12'd0, 1'b1, 1'b0, 12'd1, 32'h0);
    repeat (65535) @(posedge w_clk);
    #1;
    checks++; if (bus.r_dcnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_full got=%0h exp=ffff", bus.r_dcnt); end
    next_cycle();
    checks++; if (bus.r_dcnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%0h exp=0", bus.r_dcnt); end
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'h0);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_word(i);
    test_reset();
    test_iread();
    test_arbitrate("starve", 8, 16'h00FF, 16'h00FF, 16'h0088, 16'h0077);
    test_arbitrate("starve_clr", 8, 16'h00FB, 16'h00FF, 16'h0040, 16'h00BF);
    test_arbitrate("single", 4, 16'h0005, 16'h000A, 16'h0005, 16'h000A);
    test_write_read();
    test_reset_mid();
    test_idle();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
